// File: rtl/sr_mem_ctrl_pkg.sv
// Shared definitions for the scratch-RAM memory controller and the CPU control path:
// AGU request codes, controller state encoding and default geometry.
package sr_mem_ctrl_pkg;

    localparam int NODE_W_DEF   = 4;
    localparam int LOCAL_AW_DEF = 10;

    localparam logic [2:0] AGU_IDLE  = 3'd0;
    localparam logic [2:0] AGU_LOAD  = 3'd1;
    localparam logic [2:0] AGU_STORE = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } memState_t;

    function automatic logic isMemOp(input logic [2:0] code);
        return (code == AGU_LOAD) || (code == AGU_STORE);
    endfunction

endpackage

// File: rtl/sr_mem_ctrl_if.sv
// Remote request/response bus between a core's memory controller (master)
// and the interconnect that serves other nodes' RAMs (slave).
interface sr_mem_ctrl_if
    import sr_mem_ctrl_pkg::*;
#(
    parameter int NODE_W   = NODE_W_DEF,
    parameter int LOCAL_AW = LOCAL_AW_DEF
);
    logic                req_valid;
    logic                req_ready;
    logic [NODE_W-1:0]   req_node;
    logic [LOCAL_AW-1:0] req_addr;
    logic                req_we;
    logic [31:0]         req_data;
    logic                rsp_valid;
    logic [31:0]         rsp_data;

    modport master (
        output req_valid, req_node, req_addr, req_we, req_data,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_node, req_addr, req_we, req_data,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/sr_mem_ctrl_local_ram.sv
// Single-port local scratch RAM: synchronous write, registered read (1-cycle latency).
// Contents are deliberately not reset so the array maps onto block RAM.
module sr_local_ram
    import sr_mem_ctrl_pkg::*;
#(
    parameter int AW = LOCAL_AW_DEF
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/sr_mem_ctrl.sv
// Per-core memory controller: serves loads/stores addressed to this node from the
// local RAM and forwards all others over the remote request/response bus.
module sr_mem_ctrl
    import sr_mem_ctrl_pkg::*;
#(
    parameter int NODE_ID  = 0,
    parameter int NODE_W   = NODE_W_DEF,
    parameter int LOCAL_AW = LOCAL_AW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          aguInstructionOut,
    input  logic [31:0]         ramAddress,
    input  logic [31:0]         dataFromCpu,
    output logic                instrSuccess,
    output logic [31:0]         dataToCpu,
    sr_mem_ctrl_if.master       remoteBus
);
    localparam int NODE_LSB = LOCAL_AW + 2;
    localparam int NODE_MSB = LOCAL_AW + NODE_W + 1;
    localparam logic [NODE_W-1:0] MY_NODE = NODE_W'(NODE_ID);

    memState_t           stateReg, stateNext;
    logic                reqValidReg;
    logic [NODE_W-1:0]   reqNodeReg;
    logic [LOCAL_AW-1:0] reqAddrReg;
    logic                reqWeReg;
    logic [31:0]         reqDataReg;
    logic [31:0]         dataReg;
    logic                localLoadReg;

    logic [LOCAL_AW-1:0] wordIdx;
    logic [NODE_W-1:0]   nodeField;
    logic                isMem, isStore, isLocal;
    logic                ramEn;
    logic [31:0]         ramRdata;
    logic                unusedAddrBits;

    // Byte offset and bits above the node field are ignored, so addresses alias.
    assign wordIdx        = ramAddress[LOCAL_AW+1:2];
    assign nodeField      = ramAddress[NODE_MSB:NODE_LSB];
    assign unusedAddrBits = ^{ramAddress[31:NODE_MSB+1], ramAddress[1:0]};

    assign isMem   = isMemOp(aguInstructionOut);
    assign isStore = (aguInstructionOut == AGU_STORE);
    assign isLocal = (nodeField == MY_NODE);

    sr_local_ram #(.AW(LOCAL_AW)) u_ram (
        .clk   (clk),
        .en    (ramEn),
        .we    (isStore),
        .addr  (wordIdx),
        .wdata (dataFromCpu),
        .rdata (ramRdata)
    );

    always_comb begin
        stateNext = stateReg;
        ramEn     = 1'b0;
        case (stateReg)
            ST_IDLE: begin
                if (isMem) begin
                    // Local access is issued only from IDLE, so a store writes once.
                    ramEn     = isLocal;
                    stateNext = isLocal ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ:  if (remoteBus.req_ready) stateNext = ST_WAIT;
            ST_WAIT: if (remoteBus.rsp_valid) stateNext = ST_DONE;
            ST_DONE: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg     <= ST_IDLE;
            reqValidReg  <= 1'b0;
            reqNodeReg   <= '0;
            reqAddrReg   <= '0;
            reqWeReg     <= 1'b0;
            reqDataReg   <= '0;
            dataReg      <= '0;
            localLoadReg <= 1'b0;
        end else begin
            stateReg <= stateNext;
            case (stateReg)
                ST_IDLE: begin
                    if (isMem) begin
                        localLoadReg <= isLocal && !isStore;
                        if (!isLocal) begin
                            reqValidReg <= 1'b1;
                            reqNodeReg  <= nodeField;
                            reqAddrReg  <= wordIdx;
                            reqWeReg    <= isStore;
                            reqDataReg  <= dataFromCpu;
                        end
                    end
                end
                ST_REQ: begin
                    if (remoteBus.req_ready) reqValidReg <= 1'b0;
                end
                ST_WAIT: begin
                    // Write acknowledges carry no data and must not disturb dataToCpu.
                    if (remoteBus.rsp_valid && !reqWeReg) dataReg <= remoteBus.rsp_data;
                end
                ST_DONE: begin
                    if (localLoadReg) dataReg <= ramRdata;
                    localLoadReg <= 1'b0;
                end
            endcase
        end
    end

    // Local read data arrives straight from the RAM in DONE and is latched for hold.
    assign instrSuccess = (stateReg == ST_DONE);
    assign dataToCpu    = (stateReg == ST_DONE && localLoadReg) ? ramRdata : dataReg;

    assign remoteBus.req_valid = reqValidReg;
    assign remoteBus.req_node  = reqNodeReg;
    assign remoteBus.req_addr  = reqAddrReg;
    assign remoteBus.req_we    = reqWeReg;
    assign remoteBus.req_data  = reqDataReg;
endmodule

// File: tb/tb_sr_mem_ctrl.sv
// Directed bench for sr_mem_ctrl (NODE_ID=0): local and remote accesses,
// back-to-back requests, stray responses, address aliasing and reset mid-transaction.
module tb_sr_mem_ctrl;
    import sr_mem_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [2:0]  aguInstructionOut;
    logic [31:0] ramAddress;
    logic [31:0] dataFromCpu;
    logic        instrSuccess;
    logic [31:0] dataToCpu;
    int          total;
    int          bad;

    sr_mem_ctrl_if #(.NODE_W(4), .LOCAL_AW(10)) bus ();

    sr_mem_ctrl #(.NODE_ID(0), .NODE_W(4), .LOCAL_AW(10)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .aguInstructionOut (aguInstructionOut),
        .ramAddress        (ramAddress),
        .dataFromCpu       (dataFromCpu),
        .instrSuccess      (instrSuccess),
        .dataToCpu         (dataToCpu),
        .remoteBus         (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total++; if (instrSuccess !== 1'b0) begin bad++; $display("FAIL reset_success: got %b expected 0", instrSuccess); end
        total++; if (dataToCpu !== 32'h0) begin bad++; $display("FAIL reset_data: got %h expected 00000000", dataToCpu); end
        total++; if (bus.req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b expected 0", bus.req_valid); end
        total++; if ({bus.req_node, bus.req_addr, bus.req_we, bus.req_data} !== 47'h0) begin bad++;
            $display("FAIL reset_req_fields: got node=%h addr=%h we=%b data=%h expected all 0", bus.req_node, bus.req_addr, bus.req_we, bus.req_data); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        total++; if (instrSuccess !== 1'b0) begin bad++; $display("FAIL reset_release_idle: got %b expected 0", instrSuccess); end
        $display("txn reset: done");
    endtask

    task automatic test_local_store_load();
        aguInstructionOut = AGU_STORE; ramAddress = 32'h10; dataFromCpu = 32'hDEADBEEF;
        tick();
        total++; if (instrSuccess !== 1'b1) begin bad++; $display("FAIL local_store_latency: got %b expected 1", instrSuccess); end
        total++; if (bus.req_valid !== 1'b0) begin bad++; $display("FAIL local_store_no_remote: got %b expected 0", bus.req_valid); end
        aguInstructionOut = AGU_IDLE;
        tick();
        total++; if (instrSuccess !== 1'b0) begin bad++; $display("FAIL local_store_one_pulse: got %b expected 0", instrSuccess); end
        $display("txn local store addr=00000010 data=deadbeef");
        aguInstructionOut = AGU_LOAD; ramAddress = 32'h10;
        tick();
        total++; if (instrSuccess !== 1'b1) begin bad++; $display("FAIL local_load_latency: got %b expected 1", instrSuccess); end
        total++; if (dataToCpu !== 32'hDEADBEEF) begin bad++; $display("FAIL local_load_data: got %h expected deadbeef", dataToCpu); end
        aguInstructionOut = AGU_IDLE;
        tick();
        total++; if (instrSuccess !== 1'b0) begin bad++; $display("FAIL local_load_one_pulse: got %b expected 0", instrSuccess); end
        total++; if (dataToCpu !== 32'hDEADBEEF) begin bad++; $display("FAIL local_load_hold: got %h expected deadbeef", dataToCpu); end
        $display("txn local load addr=00000010 data=%h", dataToCpu);
    endtask

    task automatic test_remote_load();
        int pulses;
        pulses = 0;
        aguInstructionOut = AGU_LOAD; ramAddress = 32'h1000; bus.req_ready = 1'b0;
        tick();
        total++; if (bus.req_valid !== 1'b1) begin bad++; $display("FAIL remote_load_valid: got %b expected 1", bus.req_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.req_valid !== 1'b1 || bus.req_node !== 4'd1 || bus.req_addr !== 10'd0 || bus.req_we !== 1'b0) begin bad++;
                $display("FAIL remote_load_hold%0d: got valid=%b node=%h addr=%h we=%b expected 1/1/000/0", i, bus.req_valid, bus.req_node, bus.req_addr, bus.req_we); end
            if (instrSuccess === 1'b1) pulses++;
        end
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
        total++; if (bus.req_valid !== 1'b0) begin bad++; $display("FAIL remote_load_valid_drop: got %b expected 0", bus.req_valid); end
        if (instrSuccess === 1'b1) pulses++;
        tick(); if (instrSuccess === 1'b1) pulses++;
        tick(); if (instrSuccess === 1'b1) pulses++;
        total++; if (pulses !== 0) begin bad++; $display("FAIL remote_load_early_success: got %0d pulses expected 0", pulses); end
        bus.rsp_valid = 1'b1; bus.rsp_data = 32'h12345678;
        tick();
        bus.rsp_valid = 1'b0; bus.rsp_data = 32'h0;
        total++; if (instrSuccess !== 1'b1) begin bad++; $display("FAIL remote_load_success: got %b expected 1", instrSuccess); end
        total++; if (dataToCpu !== 32'h12345678) begin bad++; $display("FAIL remote_load_data: got %h expected 12345678", dataToCpu); end
        aguInstructionOut = AGU_IDLE;
        tick();
        total++; if (instrSuccess !== 1'b0 || dataToCpu !== 32'h12345678) begin bad++;
            $display("FAIL remote_load_after: got success=%b data=%h expected 0/12345678", instrSuccess, dataToCpu); end
        $display("txn remote load addr=00001000 data=%h", dataToCpu);
    endtask

    task automatic test_remote_store();
        aguInstructionOut = AGU_STORE; ramAddress = 32'h2008; dataFromCpu = 32'hCAFEF00D; bus.req_ready = 1'b1;
        tick();
        total++; if (bus.req_valid !== 1'b1 || bus.req_node !== 4'd2 || bus.req_addr !== 10'd2 || bus.req_we !== 1'b1 || bus.req_data !== 32'hCAFEF00D) begin bad++;
            $display("FAIL remote_store_req: got valid=%b node=%h addr=%h we=%b data=%h expected 1/2/002/1/cafef00d", bus.req_valid, bus.req_node, bus.req_addr, bus.req_we, bus.req_data); end
        tick();
        bus.req_ready = 1'b0;
        total++; if (bus.req_valid !== 1'b0 || instrSuccess !== 1'b0) begin bad++;
            $display("FAIL remote_store_wait: got valid=%b success=%b expected 0/0", bus.req_valid, instrSuccess); end
        bus.rsp_valid = 1'b1; bus.rsp_data = 32'hFFFFFFFF;
        tick();
        bus.rsp_valid = 1'b0; bus.rsp_data = 32'h0;
        total++; if (instrSuccess !== 1'b1) begin bad++; $display("FAIL remote_store_success: got %b expected 1", instrSuccess); end
        total++; if (dataToCpu !== 32'h12345678) begin bad++; $display("FAIL remote_store_data_hold: got %h expected 12345678", dataToCpu); end
        aguInstructionOut = AGU_IDLE;
        tick();
        $display("txn remote store addr=00002008 data=cafef00d");
    endtask

    task automatic test_back_to_back();
        logic [2:0] seenPulse;
        aguInstructionOut = AGU_LOAD; ramAddress = 32'h10;
        for (int i = 0; i < 3; i++) begin
            tick();
            seenPulse[i] = instrSuccess;
            if (instrSuccess === 1'b1) begin
                total++; if (dataToCpu !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_data%0d: got %h expected deadbeef", i, dataToCpu); end
            end
        end
        aguInstructionOut = AGU_IDLE;
        total++; if (seenPulse !== 3'b101) begin bad++; $display("FAIL b2b_pulses: got %b expected 101", seenPulse); end
        tick();
        total++; if (instrSuccess !== 1'b0) begin bad++; $display("FAIL b2b_end: got %b expected 0", instrSuccess); end
        $display("txn back-to-back loads addr=00000010 pulses=%b", seenPulse);
    endtask

    task automatic test_stray_rsp();
        bus.rsp_valid = 1'b1; bus.rsp_data = 32'hBAD0BAD0;
        tick(); tick();
        bus.rsp_valid = 1'b0; bus.rsp_data = 32'h0;
        total++; if (instrSuccess !== 1'b0 || bus.req_valid !== 1'b0 || dataToCpu !== 32'hDEADBEEF) begin bad++;
            $display("FAIL stray_idle: got success=%b valid=%b data=%h expected 0/0/deadbeef", instrSuccess, bus.req_valid, dataToCpu); end
        aguInstructionOut = AGU_LOAD; ramAddress = 32'h10;
        tick();
        total++; if (instrSuccess !== 1'b1 || dataToCpu !== 32'hDEADBEEF) begin bad++;
            $display("FAIL stray_then_load: got success=%b data=%h expected 1/deadbeef", instrSuccess, dataToCpu); end
        aguInstructionOut = AGU_IDLE;
        tick();
        $display("txn stray response then load data=deadbeef");
    endtask

    task automatic test_alias();
        aguInstructionOut = AGU_STORE; ramAddress = 32'h13; dataFromCpu = 32'h0BADF00D;
        tick();
        total++; if (instrSuccess !== 1'b1) begin bad++; $display("FAIL alias_store_success: got %b expected 1", instrSuccess); end
        aguInstructionOut = AGU_IDLE;
        tick();
        aguInstructionOut = AGU_LOAD; ramAddress = 32'h10;
        tick();
        total++; if (instrSuccess !== 1'b1 || dataToCpu !== 32'h0BADF00D) begin bad++;
            $display("FAIL alias_low_bits: got success=%b data=%h expected 1/0badf00d", instrSuccess, dataToCpu); end
        aguInstructionOut = AGU_IDLE;
        tick();
        aguInstructionOut = AGU_LOAD; ramAddress = 32'h80000010;
        tick();
        total++; if (instrSuccess !== 1'b1 || dataToCpu !== 32'h0BADF00D || bus.req_valid !== 1'b0) begin bad++;
            $display("FAIL alias_high_bits: got success=%b data=%h valid=%b expected 1/0badf00d/0", instrSuccess, dataToCpu, bus.req_valid); end
        aguInstructionOut = AGU_IDLE;
        tick();
        $display("txn alias store 00000013 / load 00000010,80000010 data=0badf00d");
    endtask

    task automatic test_reset_in_wait();
        aguInstructionOut = AGU_LOAD; ramAddress = 32'h1004; bus.req_ready = 1'b1;
        tick();
        total++; if (bus.req_valid !== 1'b1 || bus.req_addr !== 10'd1) begin bad++;
            $display("FAIL rstwait_req: got valid=%b addr=%h expected 1/001", bus.req_valid, bus.req_addr); end
        tick();
        bus.req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (instrSuccess !== 1'b0 || dataToCpu !== 32'h0 || bus.req_valid !== 1'b0 || bus.req_node !== 4'd0 || bus.req_addr !== 10'd0) begin bad++;
            $display("FAIL rstwait_async: got success=%b data=%h valid=%b node=%h addr=%h expected all 0", instrSuccess, dataToCpu, bus.req_valid, bus.req_node, bus.req_addr); end
        aguInstructionOut = AGU_IDLE;
        tick(); tick();
        rst_n = 1'b1;
        bus.rsp_valid = 1'b1; bus.rsp_data = 32'h55555555;
        tick();
        bus.rsp_valid = 1'b0; bus.rsp_data = 32'h0;
        total++; if (instrSuccess !== 1'b0 || dataToCpu !== 32'h0) begin bad++;
            $display("FAIL rstwait_late_rsp: got success=%b data=%h expected 0/00000000", instrSuccess, dataToCpu); end
        tick();
        aguInstructionOut = AGU_LOAD; ramAddress = 32'h10;
        tick();
        total++; if (instrSuccess !== 1'b1 || dataToCpu !== 32'h0BADF00D) begin bad++;
            $display("FAIL rstwait_recover: got success=%b data=%h expected 1/0badf00d", instrSuccess, dataToCpu); end
        aguInstructionOut = AGU_IDLE;
        tick();
        $display("txn reset in WAIT then local load data=0badf00d");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        aguInstructionOut = AGU_IDLE;
        ramAddress    = 32'h0;
        dataFromCpu   = 32'h0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = 32'h0;
        test_reset();
        test_local_store_load();
        test_remote_load();
        test_remote_store();
        test_back_to_back();
        test_stray_rsp();
        test_alias();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sr_mem_ctrl.md
SR_MEM_CTRL -- requirements
Module: sr_mem_ctrl

Interface
REQ-001 Parameter NODE_ID, default 0: this core's node number; requests addressed to it are served locally.
REQ-002 Parameter NODE_W, default 4: width of the node field in an address.
REQ-003 Parameter LOCAL_AW, default 10: word-address width of the local RAM (1024 x 32).
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 aguInstructionOut  in  3  CPU request code: AGU_LOAD, AGU_STORE, anything else = idle.
REQ-007 ramAddress  in  32  CPU byte address; held stable by the CPU until instrSuccess.
REQ-008 dataFromCpu  in  32  store data; held stable by the CPU until instrSuccess.
REQ-009 instrSuccess  out  1  one-cycle completion pulse for the current request.
REQ-010 dataToCpu  out  32  load result; valid in the instrSuccess cycle.
REQ-011 req_valid / req_ready  out / in  1 / 1  remote request handshake.
REQ-012 req_node / req_addr / req_we / req_data  out  NODE_W / LOCAL_AW / 1 / 32  remote request: target node, word address, write flag, store data.
REQ-013 rsp_valid / rsp_data  in  1 / 32  remote response (read data, or write acknowledge); no ready, accepted only in WAIT.

Function
REQ-014 Word index = ramAddress[LOCAL_AW+1:2]; node field = ramAddress[LOCAL_AW+NODE_W+1:LOCAL_AW+2]; bits [1:0] are ignored; higher bits are ignored (aliasing).
REQ-015 States: IDLE, REQ, WAIT, DONE.
REQ-016 IDLE: a LOAD or STORE with node == NODE_ID issues the local RAM access this cycle (a store writes exactly once) and goes to DONE.
REQ-017 IDLE: a LOAD or STORE with node != NODE_ID registers req_node, req_addr, req_we, req_data, asserts req_valid and goes to REQ.
REQ-018 REQ: req_valid and all req_* fields stay constant until a cycle with req_ready=1; that cycle deasserts req_valid and moves to WAIT.
REQ-019 WAIT: the first cycle with rsp_valid=1 captures rsp_data (for loads only) and moves to DONE; WAIT has no timeout.
REQ-020 DONE: instrSuccess=1 for exactly this cycle; dataToCpu holds the local read data or the captured remote data; the next state is unconditionally IDLE.
REQ-021 Latency: local load or store = 2 cycles from request to instrSuccess; remote = 2 + handshake wait + response wait cycles, minimum 4.
REQ-022 A request is never accepted in the DONE cycle. Back-to-back identical requests are therefore executed twice, once per instruction.
REQ-023 rsp_valid outside WAIT is ignored and changes no state.
REQ-024 Remote stores complete only after the rsp_valid acknowledge, which keeps each core's accesses in program order.
REQ-025 dataToCpu holds its last value until the next load completes; after a store its value is don't-care but it does not toggle.
REQ-026 An idle or unknown request code in IDLE produces no RAM access, no req_valid and no state change.

Reset
REQ-027 Asserting rst_n low forces, asynchronously: state=IDLE, instrSuccess=0, dataToCpu=0, req_valid=0, req_node/req_addr/req_we/req_data=0.
REQ-028 A reset during REQ or WAIT abandons the transaction; a response arriving after release is ignored per REQ-023.
REQ-029 Local RAM contents are not reset.

Structure
REQ-030 State encoding and the AGU request-code constants live in the shared package/defines used by the CPU control path; NODE_W and LOCAL_AW defaults also go there.
REQ-031 The local memory is one sub-module, sr_local_ram: single-port, synchronous write, registered read with 1-cycle latency, depth 2^LOCAL_AW.
REQ-032 The FSM, address decode and remote request/response registers stay in sr_mem_ctrl.

Verification
REQ-033 NODE_ID=0: STORE 0xDEADBEEF to 0x00000010, then LOAD 0x00000010 -> each gets instrSuccess on cycle 2; the load returns 0xDEADBEEF.
REQ-034 LOAD 0x00001000 (node 1) with req_ready held low for 3 cycles, then rsp 0x12345678 two cycles later -> req_* fields stable throughout; req_node=1, req_addr=0; instrSuccess once; dataToCpu=0x12345678.
REQ-035 Two consecutive LOADs to the same local address -> two separate instrSuccess pulses with at least one cycle between them.
REQ-036 Stray rsp_valid in IDLE, then a local load of a known word -> stray data never appears on dataToCpu; the state is unaffected.
REQ-037 rst_n pulsed low during WAIT, then the response arrives -> outputs are 0 immediately; no instrSuccess; the next local request completes normally.
REQ-038 STORE to 0x00000013 then LOAD 0x00000010 -> same word; the stored data is returned.
